// File: rtl/fmap_stream_reader_pkg.sv
// Shared types and sizing helpers for the feature-map stream reader and its window logic.
// Defaults describe a 28x28 map of 32-bit pixels read through a 16-bit address port.
package fmap_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_IMG_WIDTH   = 28;
  localparam int DEF_IMG_HEIGHT  = 28;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH  = 16;
  localparam int DEF_KERNEL_SIZE = 5;

  function automatic int pix_count(input int w, input int h);
    return w * h;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fmap_stream_reader_if.sv
// Control, memory-read and pixel-output signals of the stream reader.
// master = the reader itself; slave = layer controller, memory and line_buffer side.
interface fmap_stream_reader_if
  import fmap_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic                  stall;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_en;
  logic                  win_valid;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, base_addr, stall, mem_rd_data,
    output mem_rd_en, mem_addr, out_data, out_en, win_valid, busy, done
  );

  modport slave (
    output start, base_addr, stall, mem_rd_data,
    input  mem_rd_en, mem_addr, out_data, out_en, win_valid, busy, done
  );

endinterface

// File: rtl/fmap_stream_reader_raster_counter.sv
// Column/row position of a raster scan: advances on en_i, col wraps into row, row wraps to 0.
// Zero latency from en_i to the next registered position; clr_i has priority over en_i.
module raster_counter
  import fmap_stream_reader_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int COL_W      = cnt_w(IMG_WIDTH),
  parameter int ROW_W      = cnt_w(IMG_HEIGHT)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (en_i) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o = col_q;
  assign row_o = row_q;

endmodule

// File: rtl/fmap_stream_reader.sv
// Streams one feature map from synchronous memory in raster order: first out_en 3 cycles after start, 1 pixel/cycle.
// stall freezes the read/emit pipeline for exactly one cycle per stalled cycle; the memory holds the pending word.
module fmap_stream_reader
  import fmap_stream_reader_pkg::*;
#(
  parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  fmap_stream_reader_if.master bus
);

  localparam int N     = pix_count(IMG_WIDTH, IMG_HEIGHT);
  localparam int IDX_W = cnt_w(N);
  localparam int COL_W = cnt_w(IMG_WIDTH);
  localparam int ROW_W = cnt_w(IMG_HEIGHT);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [COL_W-1:0] COL_MIN  = COL_W'(KERNEL_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(KERNEL_SIZE - 1);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  v1_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_en_q;
  logic                  win_valid_q;

  logic             rd_en;
  logic             emit;
  logic             start_acc;
  logic             win_ok;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  assign rd_en     = (state_q == ST_RUN) && !bus.stall;
  assign emit      = v1_q && !bus.stall;
  assign start_acc = (state_q == ST_IDLE) && bus.start;
  // Coordinates are those of the pixel being emitted this edge, before the counter advances.
  assign win_ok    = (row >= ROW_MIN) && (col >= COL_MIN);

  raster_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .COL_W     (COL_W),
    .ROW_W     (ROW_W)
  ) u_pos (
    .clk    (clk),
    .reset_n(reset_n),
    .clr_i  (start_acc),
    .en_i   (emit),
    .col_o  (col),
    .row_o  (row)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      idx_q       <= '0;
      v1_q        <= 1'b0;
      out_data_q  <= '0;
      out_en_q    <= 1'b0;
      win_valid_q <= 1'b0;
    end else begin
      if (!bus.stall) v1_q <= rd_en;
      out_en_q    <= emit;
      win_valid_q <= emit && win_ok;
      if (emit) out_data_q <= bus.mem_rd_data;

      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            base_q  <= bus.base_addr;
            idx_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (rd_en) begin
            idx_q <= idx_q + 1'b1;
            if (idx_q == IDX_LAST) state_q <= ST_DRAIN;
          end
        end
        // Only the final read can be pending here; once it has been emitted v1 is clear.
        ST_DRAIN: begin
          if (out_en_q && !v1_q) state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr  = (state_q == ST_RUN) ? base_q + ADDR_WIDTH'(idx_q) : '0;
  assign bus.out_data  = out_data_q;
  assign bus.out_en    = out_en_q;
  assign bus.win_valid = win_valid_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);

endmodule

// File: doc/fmap_stream_reader.md
Name: fmap_stream_reader

Overview:
Reads one IMG_WIDTH x IMG_HEIGHT feature map from a synchronous on-chip memory in raster order. It emits one pixel per enabled cycle on out_data/out_en, which drive the data input and enable of the line_buffer chain feeding the convolution window. It flags win_valid when enough rows and columns have been shifted in for a full KERNEL_SIZE x KERNEL_SIZE window. It handles the start/done handshake with the layer controller and freezes cleanly on downstream stall.

Parameters:
IMG_WIDTH, 28, pixels per row
IMG_HEIGHT, 28, rows per map
DATA_WIDTH, 32, pixel width
ADDR_WIDTH, 16, memory address width
KERNEL_SIZE, 5, window size used for win_valid

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  synchronous active-low reset
start  in  1  begin streaming; sampled only in IDLE
base_addr  in  ADDR_WIDTH  address of pixel (0,0); latched when start is accepted
stall  in  1  downstream asks for no pixel on the next cycle
mem_rd_en  out  1  memory read strobe
mem_addr  out  ADDR_WIDTH  memory read address
mem_rd_data  in  DATA_WIDTH  read data, valid the cycle after mem_rd_en; memory holds it until the next mem_rd_en
out_data  out  DATA_WIDTH  pixel to the line_buffer input
out_en  out  1  one-cycle pulse per pixel; drives the line_buffer en
win_valid  out  1  qualifies out_en; full window available
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at end of map

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE, pixel index=0, row/col=0, v1=0. out_data=0; out_en, win_valid, busy, done, mem_rd_en=0; mem_addr=0. Applies mid-operation and abandons any in-flight read.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: on start=1, latch base_addr, clear idx, go to RUN. A start asserted in any other state is ignored.
- RUN:
  - mem_rd_en = ~stall (combinational); mem_addr = base + idx, modulo 2^ADDR_WIDTH.
  - idx increments on each issued read.
  - After issuing idx = N-1 (N = IMG_WIDTH*IMG_HEIGHT), go to DRAIN.
- Pipeline:
  - v1 marks a read issued last cycle. When stall=0, v1 <= mem_rd_en; when stall=1, v1 holds.
  - Registered out_en <= v1 & ~stall. When that term is 1, out_data <= mem_rd_data; otherwise out_data holds.
  - Data from a read caught by a stall is emitted after stall drops, relying on the memory holding its output.
- DRAIN: no reads issued. When the last pixel is emitted (out_en registered for pixel N-1), go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Coordinates:
  - col/row track the emitted pixel. col wraps at IMG_WIDTH-1 to 0 and increments row; both clear at start.
  - win_valid registered alongside out_en = out_en & (row >= KERNEL_SIZE-1) & (col >= KERNEL_SIZE-1). It is 0 whenever out_en=0.
- Timing with stall=0: start sampled at cycle 0, reads at cycles 1..N, out_en at cycles 3..N+2, done at cycle N+3.
  - busy is high cycles 1..N+3.
  - Throughput is 1 pixel/cycle.
  - Each stall cycle adds exactly one cycle.
- Stall during DRAIN or on the final pixel: hold until stall drops; no pixel is lost or duplicated.
- busy and done are derived from registered state, with no combinational path from start.

Decomposition:
- Shared package: FSM state encoding (IDLE/RUN/DRAIN/DONE), pixel-count constant N, and $clog2-derived widths for idx/row/col.
- One natural sub-module: raster_counter (col/row counter with wrap and enable), reused later by the window generator.

Test Plan:
- W=4,H=3,K=3, base=0x0100, memory word = address, stall=0 -> 12 out_en pulses, data 0x100..0x10B in order; first pulse at cycle 3, done at cycle 15.
- Same setup, win_valid check -> high only on pixels (2,2) and (2,3), i.e. data 0x10A and 0x10B.
- Stall high cycles 5-7 -> no pulses on cycles 6-8, same 12-value sequence with no loss or duplicates, done delayed by 3 cycles.
- base=0xFFFE, ADDR_WIDTH=16 -> mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, ...
- start pulsed again while busy -> ignored, exactly one done. reset_n=0 mid-RUN -> next cycle all outputs 0, state IDLE; a fresh start restarts from pixel 0.
- Stall held on the final pixel for 4 cycles -> last pixel emitted once after release, followed by a single done pulse.
